gamevisuals_vram_arbiter: RTL and testbench

- Shares the single-port 4096x32 on-chip frame/tile RAM between two requesters: the display scanout engine (read-only, latency-critical) and the CPU Avalon-MM master (read/write).
- Fixed priority goes to display, with an anti-starvation slot for the CPU.
- Also sequences a hardware clear sweep that fills the whole RAM with a constant. This sweep runs after reset or on command.
- Sits between the interconnect/scanout logic and the RAM's s1 slave signals.

---
 rtl/gamevisuals_vram_arbiter.sv | 176 +++++++++++++++++
 tb/tb_gamevisuals_vram_arbiter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gamevisuals_vram_arbiter.sv
// Shares the single-port frame/tile RAM between display scanout (priority) and the CPU, and runs the clear sweep.
// Optional feature macro: VRAM_ARB_PERF_EN (CPU stall-cycle counter). States: CLEAR | sweep writes CLEAR_VALUE; RUN | arbitration active.
module gamevisuals_vram_arbiter #(
    parameter int              ADDR_W         = 12,
    parameter int              DEPTH          = 4096,
    parameter int              DATA_W         = 32,
    parameter int              MAX_WAIT       = 4,
    parameter logic [DATA_W-1:0] CLEAR_VALUE  = '0,
    parameter bit              CLEAR_ON_RESET = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clear_start,
    output logic                  clear_busy,
    input  logic                  disp_req,
    input  logic [ADDR_W-1:0]     disp_addr,
    output logic                  disp_ack,
    output logic [DATA_W-1:0]     disp_rdata,
    output logic                  disp_rvalid,
    input  logic [ADDR_W-1:0]     cpu_address,
    input  logic                  cpu_read,
    input  logic                  cpu_write,
    input  logic [DATA_W/8-1:0]   cpu_byteenable,
    input  logic [DATA_W-1:0]     cpu_writedata,
    output logic                  cpu_waitrequest,
    output logic [DATA_W-1:0]     cpu_readdata,
    output logic                  cpu_readdatavalid,
    output logic [ADDR_W-1:0]     ram_address,
    output logic [DATA_W/8-1:0]   ram_byteenable,
    output logic                  ram_chipselect,
    output logic                  ram_write,
    output logic [DATA_W-1:0]     ram_writedata,
    output logic                  ram_clken,
    input  logic [DATA_W-1:0]     ram_readdata,
    output logic [31:0]           perf_stall_cnt
);

    localparam logic [ADDR_W-1:0] SWEEP_LAST = ADDR_W'(DEPTH - 1);
    localparam logic [3:0]        WAIT_MAX   = 4'(MAX_WAIT);
    localparam logic [1:0]        TAG_NONE   = 2'b00;
    localparam logic [1:0]        TAG_DISP   = 2'b01;
    localparam logic [1:0]        TAG_CPU    = 2'b10;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    localparam state_t ST_RESET = CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   sweep_q, sweep_d;
    logic [3:0]          starve_q, starve_d;
    logic [1:0]          tag_q, tag_d;
    logic [DATA_W-1:0]   disp_rdata_q, cpu_rdata_q;
    logic                disp_rvalid_q, cpu_rvalid_q;
    logic                cpu_req, disp_gnt, cpu_gnt;

    assign cpu_req = cpu_read | cpu_write;

    always_comb begin
        state_d        = state_q;
        sweep_d        = sweep_q;
        starve_d       = starve_q;
        tag_d          = TAG_NONE;
        disp_gnt       = 1'b0;
        cpu_gnt        = 1'b0;
        ram_address    = '0;
        ram_byteenable = '0;
        ram_chipselect = 1'b0;
        ram_write      = 1'b0;
        ram_writedata  = '0;
        case (state_q)
            ST_CLEAR: begin
                ram_chipselect = 1'b1;
                ram_write      = 1'b1;
                ram_byteenable = '1;
                ram_address    = sweep_q;
                ram_writedata  = CLEAR_VALUE;
                starve_d       = '0;
                if (sweep_q == SWEEP_LAST) begin
                    state_d = ST_RUN;
                    sweep_d = '0;
                end else begin
                    sweep_d = sweep_q + ADDR_W'(1);
                end
            end
            ST_RUN: begin
                // Display wins a conflict unless the CPU has already lost MAX_WAIT times in a row.
                if (disp_req && cpu_req) begin
                    cpu_gnt  = (starve_q == WAIT_MAX);
                    disp_gnt = !cpu_gnt;
                end else begin
                    disp_gnt = disp_req;
                    cpu_gnt  = cpu_req;
                end
                if (cpu_req && !cpu_gnt) begin
                    starve_d = (starve_q == WAIT_MAX) ? starve_q : starve_q + 4'd1;
                end else begin
                    starve_d = '0;
                end
                if (disp_gnt) begin
                    ram_chipselect = 1'b1;
                    ram_address    = disp_addr;
                    ram_byteenable = '1;
                    tag_d          = TAG_DISP;
                end else if (cpu_gnt) begin
                    ram_chipselect = 1'b1;
                    ram_address    = cpu_address;
                    ram_byteenable = cpu_byteenable;
                    ram_write      = cpu_write;
                    ram_writedata  = cpu_writedata;
                    tag_d          = cpu_write ? TAG_NONE : TAG_CPU;
                end
                if (clear_start) begin
                    state_d = ST_CLEAR;
                end
            end
            default: begin
                state_d = ST_RESET;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_RESET;
            sweep_q       <= '0;
            starve_q      <= '0;
            tag_q         <= TAG_NONE;
            disp_rdata_q  <= '0;
            cpu_rdata_q   <= '0;
            disp_rvalid_q <= 1'b0;
            cpu_rvalid_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            sweep_q       <= sweep_d;
            starve_q      <= starve_d;
            tag_q         <= tag_d;
            disp_rvalid_q <= (tag_q == TAG_DISP);
            cpu_rvalid_q  <= (tag_q == TAG_CPU);
            if (tag_q == TAG_DISP) begin
                disp_rdata_q <= ram_readdata;
            end
            if (tag_q == TAG_CPU) begin
                cpu_rdata_q <= ram_readdata;
            end
        end
    end

    assign clear_busy        = (state_q == ST_CLEAR);
    assign disp_ack          = disp_gnt;
    assign cpu_waitrequest   = (state_q != ST_RUN) || (cpu_req && !cpu_gnt);
    assign disp_rdata        = disp_rdata_q;
    assign disp_rvalid       = disp_rvalid_q;
    assign cpu_readdata      = cpu_rdata_q;
    assign cpu_readdatavalid = cpu_rvalid_q;
    assign ram_clken         = 1'b1;

`ifdef VRAM_ARB_PERF_EN
    logic [31:0] perf_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_q <= '0;
        end else if (cpu_waitrequest && cpu_req && (perf_q != 32'hFFFF_FFFF)) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign perf_stall_cnt = perf_q;
`else
    assign perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_gamevisuals_vram_arbiter.sv
// Directed bench for gamevisuals_vram_arbiter with a behavioural 4096x32 RAM (registered read, byte-enabled write).
module tb_gamevisuals_vram_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        clear_start;
    logic        clear_busy;
    logic        disp_req;
    logic [11:0] disp_addr;
    logic        disp_ack;
    logic [31:0] disp_rdata;
    logic        disp_rvalid;
    logic [11:0] cpu_address;
    logic        cpu_read;
    logic        cpu_write;
    logic [3:0]  cpu_byteenable;
    logic [31:0] cpu_writedata;
    logic        cpu_waitrequest;
    logic [31:0] cpu_readdata;
    logic        cpu_readdatavalid;
    logic [11:0] ram_address;
    logic [3:0]  ram_byteenable;
    logic        ram_chipselect;
    logic        ram_write;
    logic [31:0] ram_writedata;
    logic        ram_clken;
    logic [31:0] ram_readdata;
    logic [31:0] perf_stall_cnt;

    logic [31:0] mem [0:4095];
    logic        bd_fill;
    logic [31:0] bd_fill_val;
    logic        bd_we;
    logic [11:0] bd_addr;
    logic [31:0] bd_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    gamevisuals_vram_arbiter dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .clear_start       (clear_start),
        .clear_busy        (clear_busy),
        .disp_req          (disp_req),
        .disp_addr         (disp_addr),
        .disp_ack          (disp_ack),
        .disp_rdata        (disp_rdata),
        .disp_rvalid       (disp_rvalid),
        .cpu_address       (cpu_address),
        .cpu_read          (cpu_read),
        .cpu_write         (cpu_write),
        .cpu_byteenable    (cpu_byteenable),
        .cpu_writedata     (cpu_writedata),
        .cpu_waitrequest   (cpu_waitrequest),
        .cpu_readdata      (cpu_readdata),
        .cpu_readdatavalid (cpu_readdatavalid),
        .ram_address       (ram_address),
        .ram_byteenable    (ram_byteenable),
        .ram_chipselect    (ram_chipselect),
        .ram_write         (ram_write),
        .ram_writedata     (ram_writedata),
        .ram_clken         (ram_clken),
        .ram_readdata      (ram_readdata),
        .perf_stall_cnt    (perf_stall_cnt)
    );

    // RAM model; backdoor fill/write take priority over the port.
    always @(posedge clk) begin
        if (bd_fill) begin
            for (int i = 0; i < 4096; i++) mem[i] <= bd_fill_val;
        end else if (bd_we) begin
            mem[bd_addr] <= bd_data;
        end else if (ram_chipselect && ram_clken && ram_write) begin
            for (int b = 0; b < 4; b++)
                if (ram_byteenable[b]) mem[ram_address][8*b +: 8] <= ram_writedata[8*b +: 8];
        end
        if (ram_chipselect && ram_clken) ram_readdata <= mem[ram_address];
    end

    task automatic bd_write(input logic [11:0] a, input logic [31:0] d);
        @(negedge clk);
        bd_we = 1'b1; bd_addr = a; bd_data = d;
        @(negedge clk);
        bd_we = 1'b0;
    endtask

    task automatic cpu_write_tx(input logic [11:0] a, input logic [31:0] d, input logic [3:0] be);
        int n;
        @(negedge clk);
        cpu_address = a; cpu_writedata = d; cpu_byteenable = be; cpu_write = 1'b1;
        #1; n = 0;
        while (cpu_waitrequest === 1'b1 && n < 100) begin @(negedge clk); #1; n++; end
        checks++;
        if (n >= 100) begin errors++; $display("FAIL wr_accept: waitrequest never dropped, waited %0d cycles", n); end
        @(negedge clk);
        cpu_write = 1'b0;
    endtask

    task automatic cpu_read_tx(input logic [11:0] a, output logic [31:0] d, output int lat);
        int n;
        @(negedge clk);
        cpu_address = a; cpu_read = 1'b1;
        #1; n = 0;
        while (cpu_waitrequest === 1'b1 && n < 100) begin @(negedge clk); #1; n++; end
        checks++;
        if (n >= 100) begin errors++; $display("FAIL rd_accept: waitrequest never dropped, waited %0d cycles", n); end
        @(negedge clk);
        cpu_read = 1'b0; lat = 1; #1;
        while (cpu_readdatavalid !== 1'b1 && lat < 10) begin @(negedge clk); #1; lat++; end
        d = cpu_readdata;
    endtask

    task automatic test_reset();
        #1;
        checks++; if (clear_busy !== 1'b1) begin errors++; $display("FAIL rst_clear_busy: got %b want 1", clear_busy); end
        checks++; if (disp_rvalid !== 1'b0) begin errors++; $display("FAIL rst_disp_rvalid: got %b want 0", disp_rvalid); end
        checks++; if (cpu_readdatavalid !== 1'b0) begin errors++; $display("FAIL rst_cpu_rdv: got %b want 0", cpu_readdatavalid); end
        checks++; if (disp_rdata !== 32'h0) begin errors++; $display("FAIL rst_disp_rdata: got %h want 0", disp_rdata); end
        checks++; if (cpu_readdata !== 32'h0) begin errors++; $display("FAIL rst_cpu_rdata: got %h want 0", cpu_readdata); end
        checks++; if (cpu_waitrequest !== 1'b1) begin errors++; $display("FAIL rst_waitreq: got %b want 1", cpu_waitrequest); end
        checks++; if (ram_clken !== 1'b1) begin errors++; $display("FAIL rst_clken: got %b want 1", ram_clken); end
    endtask

    task automatic test_clear_on_reset();
        int busy, wr_bad, bad, lat;
        logic [31:0] d;
        @(negedge clk);
        reset_n = 1'b1; cpu_read = 1'b1; cpu_address = 12'h005;
        #1; busy = 0; wr_bad = 0;
        for (int n = 0; n < 5000 && clear_busy === 1'b1; n++) begin
            busy++;
            if (cpu_waitrequest !== 1'b1) wr_bad++;
            @(negedge clk); #1;
        end
        cpu_read = 1'b0;
        checks++; if (busy != 4096) begin errors++; $display("FAIL clr_rst_len: got %0d cycles want 4096", busy); end
        checks++; if (wr_bad != 0) begin errors++; $display("FAIL clr_rst_waitreq: %0d cycles with waitrequest low, want 0", wr_bad); end
        bad = 0;
        for (int i = 0; i < 4096; i++) if (mem[i] !== 32'h0) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL clr_rst_words: %0d nonzero words, want 0", bad); end
        cpu_read_tx(12'hFFF, d, lat);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL clr_rst_rd: got %h want 00000000", d); end
    endtask

    task automatic test_byteenable();
        logic [31:0] d;
        int lat;
        bd_write(12'h010, 32'hDEADBEEF);
        cpu_write_tx(12'h010, 32'h12345678, 4'b0011);
        cpu_read_tx(12'h010, d, lat);
        checks++; if (d !== 32'hDEAD5678) begin errors++; $display("FAIL be_data: got %h want DEAD5678", d); end
        checks++; if (lat != 2) begin errors++; $display("FAIL be_latency: got %0d want 2", lat); end
    endtask

    task automatic test_starvation();
        logic exp_cpu;
        @(negedge clk);
        disp_req = 1'b1; disp_addr = 12'h020; cpu_read = 1'b1; cpu_address = 12'h030;
        for (int i = 0; i < 10; i++) begin
            #1;
            exp_cpu = ((i % 5) == 4);
            checks++;
            if (disp_ack !== !exp_cpu) begin errors++; $display("FAIL starve_ack[%0d]: got %b want %b", i, disp_ack, !exp_cpu); end
            checks++;
            if (cpu_waitrequest !== !exp_cpu) begin errors++; $display("FAIL starve_wait[%0d]: got %b want %b", i, cpu_waitrequest, !exp_cpu); end
            @(negedge clk);
        end
        disp_req = 1'b0; cpu_read = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_disp_burst();
        logic [31:0] vals [4];
        logic exp_v;
        vals[0] = 32'hA5A5_0000; vals[1] = 32'h1111_2222;
        vals[2] = 32'h3C3C_4B4B; vals[3] = 32'hA5A5_0003;
        for (int i = 0; i < 4; i++) bd_write(12'(i), vals[i]);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            disp_req = (i < 4); disp_addr = 12'(i);
            #1;
            exp_v = (i >= 2 && i < 6);
            checks++;
            if (disp_ack !== (i < 4)) begin errors++; $display("FAIL burst_ack[%0d]: got %b want %b", i, disp_ack, (i < 4)); end
            checks++;
            if (disp_rvalid !== exp_v) begin errors++; $display("FAIL burst_rvalid[%0d]: got %b want %b", i, disp_rvalid, exp_v); end
            if (exp_v) begin
                checks++;
                if (disp_rdata !== vals[i-2]) begin errors++; $display("FAIL burst_data[%0d]: got %h want %h", i, disp_rdata, vals[i-2]); end
            end
        end
        disp_req = 1'b0;
    endtask

    task automatic test_clear_cmd();
        int busy, bad;
        logic rv;
        logic [31:0] rd;
        bd_write(12'h040, 32'hCAFEF00D);
        bd_write(12'h041, 32'h11223344);
        @(negedge clk);
        cpu_read = 1'b1; cpu_address = 12'h040; clear_start = 1'b1;
        #1;
        checks++; if (cpu_waitrequest !== 1'b0) begin errors++; $display("FAIL clrcmd_grant: got %b want 0", cpu_waitrequest); end
        @(negedge clk);
        cpu_read = 1'b0; clear_start = 1'b0;
        #1; busy = 0; rv = 1'b0; rd = '0;
        for (int n = 0; n < 5000 && clear_busy === 1'b1; n++) begin
            busy++;
            if (n == 1) begin rv = cpu_readdatavalid; rd = cpu_readdata; end
            @(negedge clk); #1;
        end
        checks++; if (rv !== 1'b1) begin errors++; $display("FAIL clrcmd_rdv: got %b want 1", rv); end
        checks++; if (rd !== 32'hCAFEF00D) begin errors++; $display("FAIL clrcmd_data: got %h want CAFEF00D", rd); end
        checks++; if (busy != 4096) begin errors++; $display("FAIL clrcmd_len: got %0d cycles want 4096", busy); end
        bad = 0;
        for (int i = 0; i < 4096; i++) if (mem[i] !== 32'h0) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL clrcmd_words: %0d nonzero words, want 0", bad); end
    endtask

    task automatic test_reset_abort();
        int late;
        @(negedge clk);
        disp_req = 1'b1; disp_addr = 12'h005;
        #1;
        checks++; if (disp_ack !== 1'b1) begin errors++; $display("FAIL abort_ack: got %b want 1", disp_ack); end
        @(negedge clk);
        disp_req = 1'b0; reset_n = 1'b0;
        #1;
        checks++; if (disp_rvalid !== 1'b0) begin errors++; $display("FAIL abort_rvalid: got %b want 0", disp_rvalid); end
        checks++; if (disp_rdata !== 32'h0) begin errors++; $display("FAIL abort_disp_rdata: got %h want 0", disp_rdata); end
        checks++; if (cpu_readdata !== 32'h0) begin errors++; $display("FAIL abort_cpu_rdata: got %h want 0", cpu_readdata); end
        checks++; if (clear_busy !== 1'b1) begin errors++; $display("FAIL abort_busy: got %b want 1", clear_busy); end
        checks++; if (cpu_waitrequest !== 1'b1) begin errors++; $display("FAIL abort_waitreq: got %b want 1", cpu_waitrequest); end
        late = 0;
        repeat (3) begin
            @(negedge clk); #1;
            if (disp_rvalid !== 1'b0 || cpu_readdatavalid !== 1'b0) late++;
        end
        checks++; if (late != 0) begin errors++; $display("FAIL abort_late_valid: %0d valid pulses after reset, want 0", late); end
`ifndef VRAM_ARB_PERF_EN
        checks++; if (perf_stall_cnt !== 32'h0) begin errors++; $display("FAIL perf_tied: got %h want 0", perf_stall_cnt); end
`endif
    endtask

    initial begin
        reset_n = 1'b1;
        clear_start = 1'b0; disp_req = 1'b0; disp_addr = '0;
        cpu_address = '0; cpu_read = 1'b0; cpu_write = 1'b0;
        cpu_byteenable = '0; cpu_writedata = '0;
        bd_fill = 1'b1; bd_fill_val = 32'hDEADBEEF;
        bd_we = 1'b0; bd_addr = '0; bd_data = '0;
        #2 reset_n = 1'b0;
        repeat (2) @(negedge clk);
        bd_fill = 1'b0;
        test_reset();
        test_clear_on_reset();
        test_byteenable();
        test_starvation();
        test_disp_burst();
        test_clear_cmd();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
